// File: rtl/cmd_ser_fifo.sv
// cmd_ser_fifo: buffers parallel register writes and serializes each one as a byte burst on the ad/stb command bus
//   clk, rst                       clock, synchronous active-high reset
//   cmd_addr, cmd_data, cmd_len    write command: address, data, burst byte count (0 -> 1, 7 -> 6)
//   cmd_valid, cmd_ready           command handshake; transfer when both high at a clock edge
//   ad, stb                        registered command bus byte and first-byte strobe
//   idle                           FIFO empty, serializer idle and bus quiet
module cmd_ser_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [2:0]            cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [7:0]            ad,
    output logic                  stb,
    output logic                  idle
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam int PW = ADDR_WIDTH + DATA_WIDTH;
    localparam int EW = PW + 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic {IDLE, SEND} state_t;
    logic [EW-1:0] mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    state_t state;
    logic [PW-9:0] sh;
    logic [2:0] cnt;
    logic act;
    logic [2:0] len_n, head_len;
    logic push, pop;
    logic [EW-1:0] head;
    always_comb begin
        len_n = cmd_len == 3'd0 ? 3'd1 : cmd_len == 3'd7 ? 3'd6 : cmd_len;
        push = cmd_valid && cmd_ready;
        pop = state == IDLE && count != '0;
        head = mem[rd_ptr];
        head_len = head[EW-1:PW];
    end
    assign cmd_ready = count != FULL;
    // act marks a byte on the bus, so the last byte of a burst still holds idle low
    assign idle = count == '0 && state == IDLE && !act;
    always_ff @(posedge clk)
        if (push && !rst) mem[wr_ptr] <= {len_n, cmd_data, cmd_addr};
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            ad     <= 8'h00;
            stb    <= 1'b0;
            act    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            // the last byte is driven from SEND while returning to IDLE, so the next pop lands on the following cycle with no gap
            if (state == SEND) begin
                ad    <= sh[7:0];
                stb   <= 1'b0;
                act   <= 1'b1;
                sh    <= sh >> 8;
                cnt   <= cnt - 3'd1;
                state <= cnt == 3'd1 ? IDLE : SEND;
            end else if (pop) begin
                ad    <= head[7:0];
                stb   <= 1'b1;
                act   <= 1'b1;
                sh    <= head[PW-1:8];
                cnt   <= head_len - 3'd1;
                state <= head_len > 3'd1 ? SEND : IDLE;
            end else begin
                ad    <= 8'h00;
                stb   <= 1'b0;
                act   <= 1'b0;
            end
        end
    end
endmodule
